// File: rtl/rng_target_scheduler_if.sv
// Game-side signal bundle for the LED reaction round sequencer.
// The master side drives control, random source and buttons; the slave side is the scheduler.
interface rng_target_scheduler_if #(
  parameter int NUM_LEDS = 18,
  parameter int RAND_W   = 5
);
  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic                start;
  logic                stop;
  logic [RAND_W-1:0]   random_value;
  logic [NUM_LEDS-1:0] buttons;
  logic [NUM_LEDS-1:0] leds;
  logic [IDX_W-1:0]    target_idx;
  logic                busy;
  logic                hit;
  logic                miss;
  logic [7:0]          hit_count;

  modport master (
    output start, stop, random_value, buttons,
    input  leds, target_idx, busy, hit, miss, hit_count
  );

  modport slave (
    input  start, stop, random_value, buttons,
    output leds, target_idx, busy, hit, miss, hit_count
  );
endinterface

// File: rtl/rng_target_scheduler.sv
// Round sequencer for the LED reaction game: dark gap, pick a non-repeating target,
// light it for a bounded window and judge the button response.
module rng_target_scheduler #(
  parameter int NUM_LEDS     = 18,
  parameter int RAND_W       = 5,
  parameter int GAP_CYCLES   = 5_000_000,
  parameter int ON_CYCLES    = 25_000_000,
  parameter int MAX_RESAMPLE = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rng_target_scheduler_if.slave bus
);
  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int ON_W  = $clog2(ON_CYCLES + 1);
  localparam int REJ_W = $clog2(MAX_RESAMPLE + 1);

  typedef enum logic [1:0] {IDLE, GAP, SAMPLE, ON} state_t;

  state_t              state_reg;
  logic [NUM_LEDS-1:0] leds_reg;
  logic [IDX_W-1:0]    target_reg;
  logic [IDX_W-1:0]    last_reg;
  logic                busy_reg;
  logic                hit_reg;
  logic                miss_reg;
  logic [7:0]          hit_count_reg;
  logic [GAP_W-1:0]    gap_cnt_reg;
  logic [ON_W-1:0]     on_cnt_reg;
  logic [REJ_W-1:0]    rej_cnt_reg;

  logic                sample_ok;
  logic                give_up;
  logic [IDX_W-1:0]    fallback_idx;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_LEDS-1:0] pick_onehot;
  logic                correct_press;
  logic                wrong_press;

  always_comb begin
    sample_ok    = (32'(bus.random_value) < NUM_LEDS) &&
                   (32'(bus.random_value) != 32'(last_reg));
    // this attempt is the one that would bring the reject count to the limit
    give_up      = (32'(rej_cnt_reg) + 1 == MAX_RESAMPLE);
    fallback_idx = (32'(last_reg) == NUM_LEDS - 1) ? '0 : last_reg + IDX_W'(1);
    pick_idx     = sample_ok ? IDX_W'(bus.random_value) : fallback_idx;
  end

  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_onehot
      assign pick_onehot[gi] = (32'(pick_idx) == gi);
    end
  endgenerate

  // leds_reg is exactly one-hot(target) while ON, so it doubles as the button mask
  assign correct_press = |(bus.buttons & leds_reg);
  assign wrong_press   = |(bus.buttons & ~leds_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      leds_reg      <= '0;
      target_reg    <= '0;
      last_reg      <= '0;
      busy_reg      <= 1'b0;
      hit_reg       <= 1'b0;
      miss_reg      <= 1'b0;
      hit_count_reg <= '0;
      gap_cnt_reg   <= '0;
      on_cnt_reg    <= '0;
      rej_cnt_reg   <= '0;
    end else begin
      hit_reg  <= 1'b0;
      miss_reg <= 1'b0;
      if (bus.stop) begin
        state_reg <= IDLE;
        leds_reg  <= '0;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.start) begin
              state_reg     <= GAP;
              busy_reg      <= 1'b1;
              gap_cnt_reg   <= GAP_W'(GAP_CYCLES);
              hit_count_reg <= '0;
            end
          end
          GAP: begin
            if (gap_cnt_reg == GAP_W'(1)) begin
              state_reg   <= SAMPLE;
              rej_cnt_reg <= '0;
            end else begin
              gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
            end
          end
          SAMPLE: begin
            if (sample_ok || give_up) begin
              target_reg <= pick_idx;
              last_reg   <= pick_idx;
              leds_reg   <= pick_onehot;
              on_cnt_reg <= ON_W'(ON_CYCLES);
              state_reg  <= ON;
            end else begin
              rej_cnt_reg <= rej_cnt_reg + REJ_W'(1);
            end
          end
          ON: begin
            if (correct_press) begin
              hit_reg     <= 1'b1;
              if (hit_count_reg != 8'hFF) hit_count_reg <= hit_count_reg + 8'd1;
              leds_reg    <= '0;
              gap_cnt_reg <= GAP_W'(GAP_CYCLES);
              state_reg   <= GAP;
            end else if (wrong_press || on_cnt_reg == ON_W'(1)) begin
              miss_reg    <= 1'b1;
              leds_reg    <= '0;
              gap_cnt_reg <= GAP_W'(GAP_CYCLES);
              state_reg   <= GAP;
            end else begin
              on_cnt_reg <= on_cnt_reg - ON_W'(1);
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.leds       = leds_reg;
  assign bus.target_idx = target_reg;
  assign bus.busy       = busy_reg;
  assign bus.hit        = hit_reg;
  assign bus.miss       = miss_reg;
  assign bus.hit_count  = hit_count_reg;
endmodule

// File: tb/tb_rng_target_scheduler.sv
// Round-level scoreboard bench for rng_target_scheduler: the driver predicts each round's
// target and outcome from the game rules; a monitor checks every hit/miss pulse.
module tb_rng_target_scheduler;
  localparam int NUM_LEDS     = 18;
  localparam int RAND_W       = 5;
  localparam int GAP_CYCLES   = 4;
  localparam int ON_CYCLES    = 10;
  localparam int MAX_RESAMPLE = 3;

  localparam int A_HIT     = 0;
  localparam int A_WRONG   = 1;
  localparam int A_BOTH    = 2;
  localparam int A_TIMEOUT = 3;
  localparam int A_STOP    = 4;

  typedef struct {
    int is_hit;
    int idx;
    int hc;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   m_last = 0;
  int   m_hc = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rng_target_scheduler_if #(.NUM_LEDS(NUM_LEDS), .RAND_W(RAND_W)) bus ();

  rng_target_scheduler #(
    .NUM_LEDS(NUM_LEDS), .RAND_W(RAND_W), .GAP_CYCLES(GAP_CYCLES),
    .ON_CYCLES(ON_CYCLES), .MAX_RESAMPLE(MAX_RESAMPLE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic chk(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int is_hit, input int idx, input int at_cyc);
    exp_t e;
    e.is_hit = is_hit;
    e.idx    = idx;
    e.hc     = m_hc;
    e.cyc    = at_cyc;
    exp_q.push_back(e);
  endtask

  // dark phase: random values and button noise must have no effect
  task automatic gap_phase();
    repeat (GAP_CYCLES) begin
      chk("gap_dark", int'(bus.leds), 0);
      bus.random_value = RAND_W'($urandom);
      bus.buttons      = NUM_LEDS'($urandom);
      tick();
    end
    bus.buttons = '0;
  endtask

  task automatic start_session();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_hc = 0;
    chk("busy_after_start", int'(bus.busy), 1);
    chk("hc_cleared", int'(bus.hit_count), 0);
    gap_phase();
  endtask

  // one round starting at the first SAMPLE cycle
  task automatic round(input int v0, input int v1, input int v2, input int action,
                       input int d, input int other, input bit gap_after);
    int vals[3];
    int tgt, rej, k, w;
    vals[0] = v0;
    vals[1] = v1;
    vals[2] = v2;
    tgt = -1;
    rej = 0;
    k   = 0;
    for (int i = 0; i < MAX_RESAMPLE && tgt < 0; i++) begin
      k++;
      if (vals[i] < NUM_LEDS && vals[i] != m_last) tgt = vals[i];
      else begin
        rej++;
        if (rej == MAX_RESAMPLE) tgt = (m_last + 1) % NUM_LEDS;
      end
    end
    for (int i = 0; i < k; i++) begin
      bus.random_value = RAND_W'(vals[i]);
      bus.buttons      = NUM_LEDS'($urandom);
      tick();
    end
    bus.buttons      = '0;
    bus.random_value = RAND_W'($urandom);
    chk("leds_onehot", int'(bus.leds), 1 << tgt);
    chk("target_idx", int'(bus.target_idx), tgt);
    m_last = tgt;
    w = (other >= 0) ? other : int'((tgt + 1 + int'($urandom_range(0, NUM_LEDS - 2))) % NUM_LEDS);

    if (action == A_TIMEOUT) begin
      push_exp(0, tgt, cyc + ON_CYCLES);
      repeat (ON_CYCLES) begin
        bus.random_value = RAND_W'($urandom);
        tick();
      end
    end else begin
      repeat (d) tick();
      case (action)
        A_HIT:   bus.buttons[tgt] = 1'b1;
        A_WRONG: bus.buttons[w] = 1'b1;
        A_BOTH:  begin bus.buttons[tgt] = 1'b1; bus.buttons[w] = 1'b1; end
        default: begin bus.stop = 1'b1; bus.buttons[tgt] = 1'b1; end
      endcase
      if (action == A_HIT || action == A_BOTH) begin
        m_hc = (m_hc == 255) ? 255 : m_hc + 1;
        push_exp(1, tgt, cyc + 1);
      end else if (action == A_WRONG) begin
        push_exp(0, tgt, cyc + 1);
      end
      tick();
      bus.buttons = '0;
      bus.stop    = 1'b0;
      if (action == A_STOP) begin
        chk("stop_busy", int'(bus.busy), 0);
        chk("stop_leds", int'(bus.leds), 0);
      end
    end
    if (action != A_STOP && gap_after) gap_phase();
  endtask

  // monitor: every hit/miss pulse must match the oldest predicted outcome
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (bus.hit || bus.miss)) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_pulse: actual hit=%0d miss=%0d required none (cycle %0d)",
                   bus.hit, bus.miss, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("hit", int'(bus.hit), e.is_hit);
          chk("miss", int'(bus.miss), 1 - e.is_hit);
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_hit_count", int'(bus.hit_count), e.hc);
          chk("pulse_leds_dark", int'(bus.leds), 0);
          chk("pulse_target", int'(bus.target_idx), e.idx);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, act;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.random_value = '0;
    bus.buttons      = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_leds", int'(bus.leds), 0);
    chk("rst_target", int'(bus.target_idx), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_hit_miss", int'(bus.hit) + int'(bus.miss), 0);
    chk("rst_hit_count", int'(bus.hit_count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // directed rounds
    start_session();
    round(7, 0, 0, A_HIT, 3, -1, 1);
    round(7, 25, 3, A_TIMEOUT, 0, -1, 1);
    round(7, 0, 0, A_HIT, ON_CYCLES - 1, -1, 1);
    round(7, 30, 7, A_WRONG, 0, -1, 1);
    round(5, 0, 0, A_WRONG, 1, 2, 1);
    round(17, 0, 0, A_HIT, 0, -1, 1);
    round(17, 17, 17, A_TIMEOUT, 0, -1, 1);
    round(5, 0, 0, A_BOTH, 2, 2, 1);
    round(3, 0, 0, A_STOP, 4, -1, 1);

    // start and stop together leave the scheduler idle
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    chk("start_stop_busy", int'(bus.busy), 0);
    bus.stop = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("start_stop_still_idle", int'(bus.busy), 0);

    // randomized session, long enough to saturate the hit counter
    start_session();
    for (int n = 0; n < 340; n++) begin
      r = int'($urandom_range(0, 99));
      act = (r < 82) ? A_HIT : (r < 88) ? A_WRONG : (r < 94) ? A_BOTH : A_TIMEOUT;
      round(($urandom_range(0, 3) == 0) ? m_last : int'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? m_last : int'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? m_last : int'($urandom_range(0, 31)),
            act, int'($urandom_range(0, ON_CYCLES - 1)), -1, (n != 339));
    end
    chk("hc_saturated", int'(bus.hit_count), 255);

    // asynchronous reset in the middle of the gap
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_leds", int'(bus.leds), 0);
    chk("midrst_target", int'(bus.target_idx), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_hit_miss", int'(bus.hit) + int'(bus.miss), 0);
    chk("midrst_hit_count", int'(bus.hit_count), 0);
    m_last = 0;
    m_hc   = 0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", int'(bus.busy), 0);
    start_session();
    round(0, 5, 0, A_HIT, 1, -1, 1);

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
